led_pattern_gen: RTL and testbench

- Multi-channel LED pattern generator; parametrised successor of the single fixed-rate status-LED blinker.
- Each channel runs one of four modes: off, steady on, blink, or burst (N flashes then a gap).
- A shared prescaler produces a base tick; each channel's pattern timing counts in ticks.
- Sits between the car control logic (mode/config registers) and the board LED pins.

---
 rtl/led_pattern_gen.sv | 116 +++++++++++
 tb/tb_led_pattern_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator (off/on/blink/burst) timed by a shared prescaled tick.
// Define LED_ACTIVE_LOW_EN to drive led active-low (0 = lit, reset value all 1s).
module led_pattern_gen #(
  parameter int CH       = 4,
  parameter int PRESCALE = 100,
  parameter int HP_W     = 16,
  parameter int BURST_W  = 3,
  parameter int GAP_HP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*CH-1:0]      mode,
  input  logic [HP_W-1:0]      half_period,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 restart,
  output logic                 tick,
  output logic [CH-1:0]        led
);
  localparam int PW = $clog2(PRESCALE);
  localparam int GW = $clog2(GAP_HP + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_HP - 1);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE_PH, ON, OFF, GAP} st_t;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick_q, tick_d;
  logic [2*CH-1:0]    mode_q;
  logic [CH-1:0]      led_q, led_d;
  logic [CH-1:0]      ph_q, ph_d;
  logic [HP_W-1:0]    hp_q [CH];
  logic [HP_W-1:0]    hp_d [CH];
  logic [BURST_W-1:0] fl_q [CH];
  logic [BURST_W-1:0] fl_d [CH];
  logic [GW-1:0]      gap_q [CH];
  logic [GW-1:0]      gap_d [CH];
  st_t                st_q [CH];
  st_t                st_d [CH];
  logic [HP_W-1:0]    lim_m1;
  st_t                burst_entry;
  assign lim_m1      = (half_period == '0) ? '0 : half_period - 1'b1;
  assign burst_entry = (burst_len == '0) ? GAP : ON;
  assign tick        = tick_q;
  assign led         = led_q;
  always_comb begin
    logic [1:0] md;
    logic       hpb;
    pre_d  = (restart || pre_q == PMAX) ? '0 : pre_q + 1'b1;
    tick_d = !restart && pre_q == PMAX;
    ph_d   = ph_q;
    led_d  = led_q;
    for (int i = 0; i < CH; i++) begin
      md       = mode[2*i +: 2];
      hpb      = tick_q && hp_q[i] >= lim_m1;
      hp_d[i]  = hp_q[i];
      fl_d[i]  = fl_q[i];
      gap_d[i] = gap_q[i];
      st_d[i]  = st_q[i];
      // Restart, a mode change or a static mode all put the channel at its entry point.
      if (restart || md != mode_q[2*i +: 2] || !md[1]) begin
        hp_d[i]  = '0;
        ph_d[i]  = 1'b0;
        fl_d[i]  = '0;
        gap_d[i] = '0;
        st_d[i]  = md[0] && md[1] ? burst_entry : IDLE_PH;
      end else if (tick_q) begin
        hp_d[i] = hpb ? '0 : hp_q[i] + 1'b1;
        if (hpb) begin
          ph_d[i] = ~ph_q[i];
          if (md[0]) begin
            case (st_q[i])
              ON:  st_d[i] = OFF;
              OFF: begin
                st_d[i] = ({1'b0, fl_q[i]} + 1'b1 < {1'b0, burst_len}) ? ON : GAP;
                fl_d[i] = (st_d[i] == ON) ? fl_q[i] + 1'b1 : '0;
                gap_d[i] = '0;
              end
              GAP: begin
                gap_d[i] = (gap_q[i] == GMAX) ? '0 : gap_q[i] + 1'b1;
                st_d[i]  = (gap_q[i] == GMAX && burst_len != '0) ? ON : GAP;
              end
              default: st_d[i] = burst_entry;
            endcase
          end
        end
      end
      led_d[i] = POL ^ (md == 2'b01 || (md == 2'b10 && ph_d[i]) || (md == 2'b11 && st_d[i] == ON));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= '0;
      led_q  <= {CH{POL}};
      ph_q   <= '0;
      hp_q   <= '{default: '0};
      fl_q   <= '{default: '0};
      gap_q  <= '{default: '0};
      st_q   <= '{default: IDLE_PH};
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      mode_q <= mode;
      led_q  <= led_d;
      ph_q   <= ph_d;
      hp_q   <= hp_d;
      fl_q   <= fl_d;
      gap_q  <= gap_d;
      st_q   <= st_d;
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: arithmetic pattern model checked every cycle, plus hand-computed timing points.
module tb_led_pattern_gen;
  localparam int P   = 100;
  localparam int GAP = 4;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mode = '0;
  logic [15:0] hp = 16'd1;
  logic [2:0]  bl = '0;
  logic        restart = 1'b0;
  logic        tick;
  logic [3:0]  led;
  int checks = 0;
  int errors = 0;
  int pcnt, ecnt;
  int ent [4];
  logic [1:0] prev [4];
  logic mtick;
  logic [3:0] mled;
  led_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .half_period(hp), .burst_len(bl),
    .restart(restart), .tick(tick), .led(led)
  );
  always #5 clk = ~clk;
  // Ticks counted since the channel last (re)entered its mode.
  function automatic int ent_next(input int c);
    logic [1:0] md;
    md = mode[2*c +: 2];
    if (restart || md != prev[c] || md < 2'd2) return 0;
    return ent[c] + (mtick ? 1 : 0);
  endfunction
  // LED from the number of completed half-periods since entry.
  function automatic logic led_of(input logic [1:0] md, input int n);
    int lim, h, per, pos;
    lim = (hp == 0) ? 1 : int'(hp);
    h   = n / lim;
    per = 2 * int'(bl) + GAP;
    pos = h % per;
    if (md == 2'd0) return 1'b0;
    if (md == 2'd1) return 1'b1;
    if (md == 2'd2) return h % 2 == 1;
    return bl != 0 && pos < 2 * int'(bl) && pos % 2 == 0;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= 0;
      ecnt  <= 0;
      mtick <= 1'b0;
      mled  <= INV;
      ent   <= '{default: 0};
      prev  <= '{default: 2'd0};
    end else begin
      pcnt  <= restart ? 0 : (pcnt + 1) % P;
      ecnt  <= restart ? 0 : ecnt + 1;
      mtick <= !restart && pcnt == P - 1;
      for (int c = 0; c < 4; c++) begin
        ent[c]  <= ent_next(c);
        prev[c] <= mode[2*c +: 2];
        mled[c] <= led_of(mode[2*c +: 2], ent_next(c)) ^ INV[c];
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (tick !== mtick || led !== mled) begin
        errors++;
        $display("FAIL model t=%0t tick=%b led=%b expected tick=%b led=%b", $time, tick, led, mtick, mled);
      end
    end
  end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask
  task automatic at(input int k);
    while (ecnt < k) @(negedge clk);
  endtask
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 400);
  endtask
  task automatic go(input logic [7:0] m, input logic [15:0] h, input logic [2:0] b);
    mode = m;
    hp = h;
    bl = b;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led ^ INV), 0);
    chk("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    wait_tick(n);
    chk("first_tick", n, 100);
    go(8'b00_00_00_10, 16'd1, 3'd0);
    at(100);
    chk("blink_100", int'(led[0] ^ INV[0]), 0);
    chk("tick_100", int'(tick), 1);
    at(101);
    chk("blink_101", int'(led[0] ^ INV[0]), 1);
    at(200);
    chk("blink_200", int'(led[0] ^ INV[0]), 1);
    at(201);
    chk("blink_201", int'(led[0] ^ INV[0]), 0);
    go(8'b00_00_00_10, 16'd1, 3'd0);
    at(100);
    chk("coll_tick", int'(tick), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("coll_led", int'(led[0] ^ INV[0]), 0);
    wait_tick(n);
    chk("coll_next_tick", n, 100);
    go(8'b01_00_11_10, 16'd0, 3'd0);
    chk("edge_0", int'(led ^ INV), 4'b1000);
    at(101);
    chk("edge_101", int'(led ^ INV), 4'b1001);
    at(500);
    chk("edge_500", int'((led ^ INV) >> 1), 3'b100);
    go(8'b00_10_00_10, 16'd1, 3'd2);
    at(150);
    chk("mc_lit", int'(led[2] ^ INV[2]), 1);
    mode[5:4] = 2'b11;
    @(negedge clk);
    chk("mc_151", int'(led[2] ^ INV[2]), 1);
    at(200);
    chk("mc_ch0_200", int'(led[0] ^ INV[0]), 1);
    at(201);
    chk("mc_ch0_201", int'(led[0] ^ INV[0]), 0);
    chk("mc_ch2_201", int'(led[2] ^ INV[2]), 0);
    at(301);
    chk("mc_ch2_301", int'(led[2] ^ INV[2]), 1);
    go(8'b00_00_11_00, 16'd2, 3'd3);
    chk("burst_0", int'(led[1] ^ INV[1]), 1);
    at(200);
    chk("burst_200", int'(led[1] ^ INV[1]), 1);
    at(201);
    chk("burst_201", int'(led[1] ^ INV[1]), 0);
    at(401);
    chk("burst_401", int'(led[1] ^ INV[1]), 1);
    at(1201);
    chk("burst_1201", int'(led[1] ^ INV[1]), 0);
    at(2000);
    chk("burst_2000", int'(led[1] ^ INV[1]), 0);
    at(2001);
    chk("burst_2001", int'(led[1] ^ INV[1]), 1);
    at(2100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", int'(led ^ INV), 0);
    chk("async_tick", int'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    chk("rel_tick", n, 100);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
